// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter with a burst limit, feeding one registered output stage.
// The owner keeps priority for up to MAX_BURST consecutive words while the other side waits.
//
// state | meaning
// IDLE  | no owner; a tie goes to the requester not served last
// OWN0  | requester 0 holds priority, cnt counts its consecutive accepts
// OWN1  | requester 1 holds priority, cnt counts its consecutive accepts
module mux_arbiter #(
  parameter int WIDTH     = 5,
  parameter int MAX_BURST = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in0_valid_i,
  input  logic [WIDTH-1:0] in0_data_i,
  output logic             in0_ready_o,
  input  logic             in1_valid_i,
  input  logic [WIDTH-1:0] in1_data_i,
  output logic             in1_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic             sel_o,
  output logic             busy_o
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             last_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             sel_q;

  logic             burst_open;
  logic             gnt_vld;
  logic             gnt;
  logic             space;
  logic             accept;
  logic             owner_match;
  logic [WIDTH-1:0] mux_data;

  assign burst_open = (cnt_q < CW'(MAX_BURST));

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    case (state_q)
      OWN0: begin
        if (in0_valid_i && (burst_open || !in1_valid_i)) begin
          gnt_vld = 1'b1;
          gnt     = 1'b0;
        end else if (in1_valid_i) begin
          gnt_vld = 1'b1;
          gnt     = 1'b1;
        end
      end
      OWN1: begin
        if (in1_valid_i && (burst_open || !in0_valid_i)) begin
          gnt_vld = 1'b1;
          gnt     = 1'b1;
        end else if (in0_valid_i) begin
          gnt_vld = 1'b1;
          gnt     = 1'b0;
        end
      end
      default: begin
        if (in0_valid_i && in1_valid_i) begin
          gnt_vld = 1'b1;
          gnt     = ~last_q;
        end else if (in0_valid_i) begin
          gnt_vld = 1'b1;
          gnt     = 1'b0;
        end else if (in1_valid_i) begin
          gnt_vld = 1'b1;
          gnt     = 1'b1;
        end
      end
    endcase
  end

  // Readies are suppressed during reset so nothing is consumed that the reset would discard.
  assign space       = ~out_valid_q | out_ready_i;
  assign sel_o       = (gnt_vld && !rst_i) ? gnt : sel_q;
  assign in0_ready_o = ~rst_i & gnt_vld & ~gnt & space & in0_valid_i;
  assign in1_ready_o = ~rst_i & gnt_vld &  gnt & space & in1_valid_i;
  assign accept      = in0_ready_o | in1_ready_o;
  assign mux_data    = sel_o ? in1_data_i : in0_data_i;
  assign owner_match = ((state_q == OWN0) && !gnt) || ((state_q == OWN1) && gnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_q       <= 1'b0;
    end else begin
      sel_q <= sel_o;
      if (accept) begin
        out_data_q  <= mux_data;
        out_valid_q <= 1'b1;
        last_q      <= gnt;
        if (owner_match) begin
          cnt_q <= burst_open ? cnt_q + CW'(1) : cnt_q;
        end else begin
          state_q <= gnt ? OWN1 : OWN0;
          cnt_q   <= CW'(1);
        end
      end else begin
        out_valid_q <= out_valid_q & ~out_ready_i;
        if (!in0_valid_i && !in1_valid_i) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed scenarios plus random traffic, all checked against an
// integer-level reference of the arbitration rules (owner, streak length, last served).
module tb_mux_arbiter;
  localparam int W  = 5;
  localparam int MB = 4;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         in0_valid_i = 1'b0, in1_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [W-1:0] in0_data_i = '0, in1_data_i = '0;
  logic         in0_ready_o, in1_ready_o, out_valid_o, sel_o, busy_o;
  logic [W-1:0] out_data_o;

  mux_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in0_valid_i(in0_valid_i), .in0_data_i(in0_data_i), .in0_ready_o(in0_ready_o),
    .in1_valid_i(in1_valid_i), .in1_data_i(in1_data_i), .in1_ready_o(in1_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
    .sel_o(sel_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference state: owner -1 means nobody holds priority
  int m_owner = -1, m_streak = 0, m_last = 1, m_ov = 0, m_od = 0, m_sel = 0;
  bit acc;
  int acc_k;
  int drained[$];

  task automatic cycle(input bit r, input bit v0, input int d0, input bit v1, input int d1,
                       input bit ordy);
    bit space, has_g;
    int g, k, o;
    int vk, vo;
    bit e_r0, e_r1;
    rst_i = r; in0_valid_i = v0; in0_data_i = W'(d0);
    in1_valid_i = v1; in1_data_i = W'(d1); out_ready_i = ordy;
    @(negedge clk_i);
    space = (m_ov == 0) || ordy;
    has_g = 0; g = 0;
    if (m_owner < 0) begin
      if (v0 && v1) begin has_g = 1; g = 1 - m_last; end
      else if (v0) begin has_g = 1; g = 0; end
      else if (v1) begin has_g = 1; g = 1; end
    end else begin
      k = m_owner; o = 1 - k;
      vk = (k == 0) ? v0 : v1;
      vo = (o == 0) ? v0 : v1;
      if (vk && (m_streak < MB || !vo)) begin has_g = 1; g = k; end
      else if (vo) begin has_g = 1; g = o; end
    end
    e_r0 = !r && has_g && g == 0 && space && v0;
    e_r1 = !r && has_g && g == 1 && space && v1;
    chk("in0_ready", in0_ready_o, e_r0);
    chk("in1_ready", in1_ready_o, e_r1);
    chk("out_valid", out_valid_o, m_ov);
    chk("out_data", out_data_o, m_od);
    chk("busy", busy_o, m_owner >= 0);
    if (!r) chk("sel", sel_o, has_g ? g : m_sel);
    acc   = e_r0 || e_r1;
    acc_k = e_r1 ? 1 : 0;
    if (m_ov != 0 && ordy) drained.push_back(m_od);
    @(posedge clk_i);
    if (r) begin
      m_owner = -1; m_streak = 0; m_last = 1; m_ov = 0; m_od = 0; m_sel = 0;
    end else begin
      if (has_g) m_sel = g;
      if (acc) begin
        m_od = (acc_k == 0) ? (d0 % 32) : (d1 % 32);
        m_ov = 1;
        m_last = acc_k;
        if (acc_k == m_owner) m_streak++;
        else begin m_owner = acc_k; m_streak = 1; end
      end else begin
        if (ordy) m_ov = 0;
        if (!v0 && !v1) begin m_owner = -1; m_streak = 0; end
      end
    end
    #1;
  endtask

  initial begin
    int d0, d1, n, exp_v, blk, pos;
    bit cv0, cv1, ordy;

    // first transfer after reset
    cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 1, 'h0A, 0, 0, 1);
    chk("first_valid", out_valid_o, 1);
    chk("first_data", out_data_o, 'h0A);
    chk("first_busy", busy_o, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // burst alternation 1,2,3,4,17,18,19,20,5,...
    cycle(1, 0, 0, 0, 0, 1);
    drained.delete();
    d0 = 1; d1 = 17;
    for (int i = 0; i < 14; i++) begin
      cycle(0, 1, d0, 1, d1, 1);
      if (acc && acc_k == 0) d0++;
      if (acc && acc_k == 1) d1++;
    end
    chk("burst_len", drained.size() >= 12, 1);
    for (int j = 0; j < 12 && j < drained.size(); j++) begin
      blk = j / MB; pos = j % MB;
      exp_v = ((blk % 2) == 0 ? 1 : 17) + (blk / 2) * MB + pos;
      chk("burst_seq", drained[j], exp_v);
    end

    // stall: output full, out_ready low for 3 cycles, then release
    for (int i = 0; i < 3; i++) cycle(0, 1, d0, 1, d1, 0);
    cycle(0, 1, d0, 1, d1, 1);
    chk("stall_release_acc", acc, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // lone requester 1 streams with no bubbles
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 1, i + 3, 1);
      if (acc) n++;
    end
    chk("in1_only_accepts", n, 10);
    chk("in1_only_sel", sel_o, 1);

    // tie-break after reset, then last=1 gives the later tie to requester 0
    cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 1, 7, 1, 9, 1);
    chk("tie0_winner", acc_k, 0);
    cycle(0, 0, 0, 1, 9, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 1, 11, 1, 12, 1);
    chk("tie1_winner", acc_k, 0);

    // reset in the middle of a burst with a word held
    cycle(0, 1, 13, 1, 12, 1);
    cycle(1, 1, 14, 1, 12, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("rst_mid_valid", out_valid_o, 0);

    // random traffic
    cv0 = 0; cv1 = 0; d0 = 0; d1 = 0;
    for (int i = 0; i < 600; i++) begin
      if (!cv0 && $urandom_range(99) < 60) begin cv0 = 1; d0 = int'($urandom_range(31)); end
      if (!cv1 && $urandom_range(99) < 60) begin cv1 = 1; d1 = int'($urandom_range(31)); end
      ordy = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 2) begin
        cycle(1, cv0, d0, cv1, d1, ordy);
      end else begin
        cycle(0, cv0, d0, cv1, d1, ordy);
        if (acc && acc_k == 0) cv0 = 0;
        if (acc && acc_k == 1) cv1 = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
